// File: rtl/display_arbiter.sv
// Round-robin arbiter that shares the two-digit hex display between N_REQ requesters.
// Each grant latches the owner's value and holds it for DWELL_CYCLES cycles.
module display_arbiter #(
    parameter int N_REQ        = 4,
    parameter int DWELL_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   value_in,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     done,
    output logic [7:0]           disp_value,
    output logic                 disp_blank
);

    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int PW = $clog2(N_REQ);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(N_REQ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [7:0]         disp_value_q, disp_value_d;
    logic               disp_blank_q, disp_blank_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [N_REQ-1:0]   served_q, served_d;

    logic [N_REQ-1:0]   eligible_s;
    logic               win_found_s;
    logic [PW-1:0]      win_idx_s;
    logic [PW-1:0]      idx_s;
    logic               hit_s;

    // Winner search: first eligible requester at or after ptr, wrapping around.
    always_comb begin
        eligible_s  = req & ~served_q;
        win_found_s = 1'b0;
        win_idx_s   = '0;
        idx_s       = '0;
        hit_s       = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx_s       = PW'((int'(ptr_q) + i) % N_REQ);
            hit_s       = eligible_s[idx_s] & ~win_found_s;
            win_idx_s   = hit_s ? idx_s : win_idx_s;
            win_found_s = win_found_s | hit_s;
        end
    end

    // Next-state and output logic; served bits drop whenever their request is low.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        done_d       = '0;
        disp_value_d = disp_value_q;
        disp_blank_d = disp_blank_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        served_d     = served_q & req;
        case (state_q)
            IDLE: begin
                if (win_found_s) begin
                    grant_d      = N_REQ'(1) << win_idx_s;
                    disp_value_d = value_in[8*win_idx_s +: 8];
                    disp_blank_d = 1'b0;
                    cnt_d        = '0;
                    ptr_d        = (win_idx_s == PTR_LAST) ? '0 : win_idx_s + PW'(1);
                    state_d      = SHOW;
                end else begin
                    grant_d      = '0;
                end
            end
            SHOW: begin
                cnt_d = cnt_q + CW'(1);
                // A dropped request aborts silently, even on the final dwell cycle.
                if ((req & grant_q) == '0) begin
                    grant_d      = '0;
                    disp_blank_d = 1'b1;
                    state_d      = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    grant_d      = '0;
                    done_d       = grant_q;
                    served_d     = (served_q & req) | grant_q;
                    disp_blank_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    state_d      = SHOW;
                end
            end
            default: begin
                grant_d      = '0;
                disp_blank_d = 1'b1;
                state_d      = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            done_q       <= '0;
            disp_value_q <= 8'h00;
            disp_blank_q <= 1'b1;
            cnt_q        <= '0;
            ptr_q        <= '0;
            served_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            disp_value_q <= disp_value_d;
            disp_blank_q <= disp_blank_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            served_q     <= served_d;
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign disp_value = disp_value_q;
    assign disp_blank = disp_blank_q;

endmodule

// File: doc/display_arbiter.md
# display_arbiter

Round-robin scheduler that shares the two-digit hex seven-segment display between up to N_REQ requesters. It sits in front of the display controller. Each requester raises a request with an 8-bit value. The arbiter grants the display to one requester at a time, latches its value and holds it on screen for a fixed dwell time. It then signals completion and moves on, blanking the display whenever no requester is being shown.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DWELL_CYCLES, 1024, display hold time per grant in clk cycles (>= 1)
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- req  input  N_REQ  per-requester request level
- value_in  input  8*N_REQ  requester i value at bits [8*i+7:8*i]
- grant  output  N_REQ  one-hot owner of the display, all-zero when idle
- done  output  N_REQ  one-cycle pulse to requester whose dwell completed
- disp_value  output  8  value for the display controller (high nibble = left digit)
- disp_blank  output  1  1 = display must be blanked (all anodes off)

## Operation
- FSM states: IDLE, SHOW.
- Registers: grant, done, disp_value, disp_blank, dwell counter cnt (width clog2(DWELL_CYCLES), min 1), round-robin pointer ptr (clog2(N_REQ)), served mask (N_REQ bits).
- eligible = req & ~served.
- IDLE:
  - If eligible is non-zero, winner = first set bit of eligible searching ptr, ptr+1, ..., wrapping modulo N_REQ.
  - At the edge: grant <= onehot(winner), disp_value <= value_in slice of winner, disp_blank <= 0, cnt <= 0, ptr <= (winner+1) mod N_REQ, state <= SHOW.
- SHOW:
  - cnt increments each cycle.
  - Normal end, cnt == DWELL_CYCLES-1: grant <= 0, done <= owner bit, served[owner] <= 1, disp_blank <= 1, state <= IDLE.
  - Abort, req[owner] == 0 in any SHOW cycle: grant <= 0, disp_blank <= 1, state <= IDLE. No done pulse and no served update. Abort takes precedence over normal end in the same cycle.
- served[i] clears on any cycle where req[i] == 0. A requester must drop req and re-raise it to be shown again. Holding req high after done never causes a regrant.
- disp_value is captured only at grant. value_in changes during SHOW are ignored. disp_value retains its last value while blanked.
- done is zero in every cycle except the single pulse cycle.
- Reset values (rst_n low at an edge, in any state): state IDLE, grant 0, done 0, disp_value 8'h00, disp_blank 1, cnt 0, ptr 0, served 0. Reset mid-SHOW aborts silently with no done pulse.

## Timing
- Request latency: eligible seen in IDLE at cycle t gives grant and disp_value valid and disp_blank = 0 at cycle t+1.
- Dwell: grant is high for exactly DWELL_CYCLES cycles, t+1 .. t+DWELL_CYCLES.
- done pulses in cycle t+DWELL_CYCLES+1, with grant = 0 and disp_blank = 1.
- Back-to-back grants have exactly one blank IDLE cycle between them: next grant at t+DWELL_CYCLES+2.
- Abort: req[owner] low in cycle k gives grant = 0 and disp_blank = 1 in cycle k+1. The next grant is possible at k+2.
- DWELL_CYCLES = 1: grant is high for one cycle and done follows in the next cycle.

## Test plan
- Reset:
  - Stimulus: rst_n low for 2 cycles with req = 4'b1111.
  - Response: grant = 0, done = 0, disp_value = 8'h00, disp_blank = 1 throughout; first grant is 4'b0001 one cycle after rst_n rises.
- Single requester (N_REQ = 4, DWELL_CYCLES = 4):
  - Stimulus: req[1] = 1 with value 8'h3C from cycle 0, held high.
  - Response: grant = 4'b0010 in cycles 1..4 with disp_value = 8'h3C; done = 4'b0010 in cycle 5; no regrant while req stays high.
  - Follow-up: drop req for 1 cycle, then re-raise; regrant occurs 1 cycle after re-raise.
- Round robin:
  - Stimulus: all four requesters raise req simultaneously after reset and hold it.
  - Response: grants go 0, 1, 2, 3, starting at cycles 1, 6, 11, 16; done pulses at 5, 10, 15, 20; no fifth grant.
- Abort:
  - Stimulus: requester 2 granted at cycle 1, drops req in cycle 2.
  - Response: grant = 0 and disp_blank = 1 in cycle 3; done is never asserted; a pending requester 3 is granted in cycle 4.
- Value latch:
  - Stimulus: value_in for the owner changes from 8'hA5 to 8'h5A mid-dwell.
  - Response: disp_value stays 8'hA5 until the grant ends.
- Reset mid-SHOW:
  - Stimulus: rst_n low in cycle 3 of a dwell.
  - Response: reset values in the following cycle, no done pulse, ptr back to 0.
